// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
// Central stall/flush sequencer for a 5-stage pipeline. Resolves data-cache
// misses, instruction refills, load-use hazards, branch redirects and halt.
// Optional build macro: HAZARD_STATS_EN adds saturating stall/flush counters;
// without it stall_cycles and flush_events are tied to zero.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_sequencer (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dREN_mem,
  input  logic        dWEN_mem,
  input  logic        dREN_ex,
  input  logic        rf_wen_ex,
  input  logic [4:0]  Rt_ex,
  input  logic [4:0]  Rs_id,
  input  logic [4:0]  Rt_id,
  input  logic        redirect_mem,
  input  logic        halt_mem,
  output logic        fd_stall,
  output logic        de_stall,
  output logic        em_stall,
  output logic        mw_stall,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        em_flush,
  output logic        mw_flush,
  output logic        pc_en,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    REFILL  = 2'b10,
    HALT    = 2'b11
  } state_t;

  state_t state_q, state_d;
  logic   redirect_pend_q, redirect_pend_d;

  logic load_use;
  logic mem_pend;

  assign load_use = dREN_ex & rf_wen_ex & (Rt_ex != 5'd0) &
                    ((Rt_ex == Rs_id) | (Rt_ex == Rt_id));
  assign mem_pend = (dREN_mem | dWEN_mem) & ~dhit;
  assign state    = state_q;
  // The MEM/WB bubble is reserved and never used by this sequencer.
  assign mw_flush = 1'b0;

  // State and deferred-redirect registers; reset drops any pending redirect.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q         <= RUN;
      redirect_pend_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      redirect_pend_q <= redirect_pend_d;
    end
  end

  // Next-state and per-stage stall/flush/PC decode.
  always_comb begin
    state_d         = state_q;
    redirect_pend_d = redirect_pend_q;
    fd_stall        = 1'b0;
    de_stall        = 1'b0;
    em_stall        = 1'b0;
    mw_stall        = 1'b0;
    fd_flush        = 1'b0;
    de_flush        = 1'b0;
    em_flush        = 1'b0;
    pc_en           = 1'b0;
    halted          = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_mem) begin
          // Halt outranks a pending miss: the core stops regardless.
          state_d = HALT;
        end else if (mem_pend) begin
          state_d  = MEMWAIT;
          fd_stall = 1'b1;
          de_stall = 1'b1;
          em_stall = 1'b1;
          mw_stall = 1'b1;
        end else if (redirect_mem & ihit) begin
          fd_flush = 1'b1;
          de_flush = 1'b1;
          em_flush = 1'b1;
          pc_en    = 1'b1;
        end else if (load_use & ihit) begin
          // Hold IF/ID and insert a bubble into ID/EX for one cycle.
          fd_stall = 1'b1;
          de_flush = 1'b1;
        end else begin
          pc_en = ihit;
        end
      end
      MEMWAIT: begin
        fd_stall = 1'b1;
        de_stall = 1'b1;
        em_stall = 1'b1;
        // Release MEM/WB in the hit cycle so it captures the load data.
        mw_stall = ~dhit;
        if (redirect_mem) redirect_pend_d = 1'b1;
        if (dhit) state_d = REFILL;
      end
      REFILL: begin
        // MEM/WB already captured the result; holding it avoids a double write.
        mw_stall = 1'b1;
        pc_en    = ihit;
        if (ihit) begin
          state_d         = RUN;
          redirect_pend_d = 1'b0;
          if (redirect_pend_q) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
          end
        end
      end
      HALT: begin
        halted   = 1'b1;
        fd_stall = 1'b1;
        de_stall = 1'b1;
        em_stall = 1'b1;
        mw_stall = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  // Saturating count of cycles the PC is frozen while the core is still live.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      stall_cycles_q <= 32'd0;
    end else if (!pc_en && !halted && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  // Saturating count of front-end flush cycles.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      flush_events_q <= 32'd0;
    end else if (fd_flush && (flush_events_q != 32'hFFFF_FFFF)) begin
      flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pipeline_sequencer
// Self-checking bench: RUN-state decode table plus multi-cycle sequences for
// miss, deferred redirect, halt, reset discard and (HAZARD_STATS_EN) counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_sequencer;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, rf_wen_ex;
  logic [4:0]  Rt_ex, Rs_id, Rt_id;
  logic        redirect_mem, halt_mem;
  logic        fd_stall, de_stall, em_stall, mw_stall;
  logic        fd_flush, de_flush, em_flush, mw_flush;
  logic        pc_en, halted;
  logic [1:0]  state;
  logic [31:0] stall_cycles, flush_events;

  pipeline_sequencer dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex),
    .rf_wen_ex(rf_wen_ex), .Rt_ex(Rt_ex), .Rs_id(Rs_id), .Rt_id(Rt_id),
    .redirect_mem(redirect_mem), .halt_mem(halt_mem),
    .fd_stall(fd_stall), .de_stall(de_stall), .em_stall(em_stall),
    .mw_stall(mw_stall), .fd_flush(fd_flush), .de_flush(de_flush),
    .em_flush(em_flush), .mw_flush(mw_flush), .pc_en(pc_en),
    .halted(halted), .state(state), .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       ihit, dhit, dren_mem, dwen_mem, dren_ex, wen_ex;
    logic [4:0] rt_ex, rs_id, rt_id;
    logic       redir, halt;
  } in_t;

  // {fd,de,em,mw} stalls, {fd,de,em,mw} flushes, pc_en, halted, state
  typedef struct packed {
    logic [3:0] stl;
    logic [3:0] fl;
    logic       pc;
    logic       hlt;
    logic [1:0] st;
  } obs_t;

  typedef struct {
    in_t   in;
    obs_t  exp;
    logic [1:0] nxt;
    string name;
  } vec_t;

  typedef struct {
    obs_t  exp;
    string name;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[14];
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic in_t mkin(input logic ih, dh, drm, dwm, dre, wen,
                               input logic [4:0] rte, rsi, rti,
                               input logic rd, hl);
    in_t v;
    v.ihit = ih; v.dhit = dh; v.dren_mem = drm; v.dwen_mem = dwm;
    v.dren_ex = dre; v.wen_ex = wen; v.rt_ex = rte; v.rs_id = rsi;
    v.rt_id = rti; v.redir = rd; v.halt = hl;
    return v;
  endfunction

  function automatic obs_t mkexp(input logic [3:0] stl, fl,
                                 input logic pc, hlt, input logic [1:0] st);
    obs_t e;
    e.stl = stl; e.fl = fl; e.pc = pc; e.hlt = hlt; e.st = st;
    return e;
  endfunction

  task automatic apply(input in_t v);
    ihit = v.ihit; dhit = v.dhit; dREN_mem = v.dren_mem; dWEN_mem = v.dwen_mem;
    dREN_ex = v.dren_ex; rf_wen_ex = v.wen_ex; Rt_ex = v.rt_ex;
    Rs_id = v.rs_id; Rt_id = v.rt_id; redirect_mem = v.redir; halt_mem = v.halt;
  endtask

  task automatic check32(input string nm, input logic [31:0] act, exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Pop one scoreboard entry and compare with the live outputs.
  task automatic check_obs();
    sb_t  s;
    obs_t a;
    a = {fd_stall, de_stall, em_stall, mw_stall,
         fd_flush, de_flush, em_flush, mw_flush, pc_en, halted, state};
    s = sb.pop_front();
    n_checks++;
    if (a === s.exp) n_pass++;
    else $display("FAIL %s: got stl=%b fl=%b pc=%b hlt=%b st=%b expected stl=%b fl=%b pc=%b hlt=%b st=%b",
                  s.name, a.stl, a.fl, a.pc, a.hlt, a.st,
                  s.exp.stl, s.exp.fl, s.exp.pc, s.exp.hlt, s.exp.st);
  endtask

  // Drive one cycle of stimulus, check mid-cycle, return just after the edge.
  task automatic step(input in_t v, input obs_t e, input string nm);
    apply(v);
    sb.push_back('{e, nm});
    @(negedge CLK);
    check_obs();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    apply(mkin(1,0,0,0,0,0,0,0,0,0,0));
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  in_t IDLE0, IDLE1, MISS, HIT, HIT_RD, MISS_RD, LU, RD;

  initial begin
    IDLE0   = mkin(0,0,0,0,0,0,0,0,0,0,0);
    IDLE1   = mkin(1,0,0,0,0,0,0,0,0,0,0);
    MISS    = mkin(0,0,1,0,0,0,0,0,0,0,0);
    MISS_RD = mkin(0,0,1,0,0,0,0,0,0,1,0);
    HIT     = mkin(0,1,1,0,0,0,0,0,0,0,0);
    HIT_RD  = mkin(1,1,0,0,0,0,0,0,0,0,0);
    LU      = mkin(1,0,0,0,1,1,5,5,0,0,0);
    RD      = mkin(1,0,0,0,0,0,0,0,0,1,0);

    // RUN-state decode vectors: inputs, outputs, next state.
    tbl[0]  = '{IDLE0, mkexp(4'b0000,4'b0000,0,0,2'b00), 2'b00, "run_idle_noihit"};
    tbl[1]  = '{IDLE1, mkexp(4'b0000,4'b0000,1,0,2'b00), 2'b00, "run_idle_ihit"};
    tbl[2]  = '{LU,    mkexp(4'b1000,4'b0100,0,0,2'b00), 2'b00, "loaduse_rs"};
    tbl[3]  = '{mkin(1,0,0,0,1,1,0,0,0,0,0), mkexp(4'b0000,4'b0000,1,0,2'b00), 2'b00, "loaduse_r0"};
    tbl[4]  = '{mkin(1,0,0,0,1,1,7,3,7,0,0), mkexp(4'b1000,4'b0100,0,0,2'b00), 2'b00, "loaduse_rt"};
    tbl[5]  = '{mkin(1,0,0,0,1,0,5,5,0,0,0), mkexp(4'b0000,4'b0000,1,0,2'b00), 2'b00, "loaduse_nowen"};
    tbl[6]  = '{mkin(0,0,0,0,1,1,5,5,0,0,0), mkexp(4'b0000,4'b0000,0,0,2'b00), 2'b00, "loaduse_noihit"};
    tbl[7]  = '{RD,    mkexp(4'b0000,4'b1110,1,0,2'b00), 2'b00, "redirect"};
    tbl[8]  = '{mkin(1,0,0,0,1,1,5,5,0,1,0), mkexp(4'b0000,4'b1110,1,0,2'b00), 2'b00, "redirect_over_lu"};
    tbl[9]  = '{mkin(0,0,0,0,0,0,0,0,0,1,0), mkexp(4'b0000,4'b0000,0,0,2'b00), 2'b00, "redirect_noihit"};
    tbl[10] = '{MISS,  mkexp(4'b1111,4'b0000,0,0,2'b00), 2'b01, "miss_enter"};
    tbl[11] = '{mkin(1,1,0,1,0,0,0,0,0,0,0), mkexp(4'b0000,4'b0000,1,0,2'b00), 2'b00, "store_hit"};
    tbl[12] = '{mkin(1,0,0,0,0,0,0,0,0,0,1), mkexp(4'b0000,4'b0000,0,0,2'b00), 2'b11, "halt"};
    tbl[13] = '{mkin(1,0,1,0,0,0,0,0,0,1,1), mkexp(4'b0000,4'b0000,0,0,2'b00), 2'b11, "halt_over_miss"};

    apply(IDLE1);
    repeat (2) @(negedge CLK);
    // Reset state: RUN decode of current inputs while nRST is low.
    sb.push_back('{mkexp(4'b0000,4'b0000,1,0,2'b00), "reset_run_decode"});
    check_obs();
    do_reset();

    for (int i = 0; i < 14; i++) begin
      do_reset();
      step(tbl[i].in, tbl[i].exp, tbl[i].name);
      check32({tbl[i].name, "_next"}, {30'd0, state}, {30'd0, tbl[i].nxt});
    end

    // Data miss held for 3 cycles, then hit, then refill.
    do_reset();
    step(MISS, mkexp(4'b1111,4'b0000,0,0,2'b00), "miss_c1");
    step(MISS, mkexp(4'b1111,4'b0000,0,0,2'b01), "miss_c2");
    step(MISS, mkexp(4'b1111,4'b0000,0,0,2'b01), "miss_c3");
    step(HIT,  mkexp(4'b1110,4'b0000,0,0,2'b01), "miss_dhit");
    step(IDLE0, mkexp(4'b0001,4'b0000,0,0,2'b10), "refill_wait");
    step(IDLE1, mkexp(4'b0001,4'b0000,1,0,2'b10), "refill_exit");
    step(IDLE0, mkexp(4'b0000,4'b0000,0,0,2'b00), "after_refill");

    // Redirect during MEMWAIT is deferred to the refill exit cycle.
    do_reset();
    step(MISS,    mkexp(4'b1111,4'b0000,0,0,2'b00), "dr_miss");
    step(MISS_RD, mkexp(4'b1111,4'b0000,0,0,2'b01), "dr_memwait_redirect");
    step(MISS,    mkexp(4'b1111,4'b0000,0,0,2'b01), "dr_memwait");
    step(HIT,     mkexp(4'b1110,4'b0000,0,0,2'b01), "dr_dhit");
    step(IDLE0,   mkexp(4'b0001,4'b0000,0,0,2'b10), "dr_refill_wait");
    step(HIT_RD,  mkexp(4'b0001,4'b1110,1,0,2'b10), "dr_refill_exit_flush");
    step(IDLE1,   mkexp(4'b0000,4'b0000,1,0,2'b00), "dr_run_after");
    step(MISS,    mkexp(4'b1111,4'b0000,0,0,2'b00), "dr2_miss");
    step(HIT,     mkexp(4'b1110,4'b0000,0,0,2'b01), "dr2_dhit");
    step(IDLE1,   mkexp(4'b0001,4'b0000,1,0,2'b10), "dr2_exit_noflush");

    // Reset while a redirect is pending discards it.
    do_reset();
    step(MISS,    mkexp(4'b1111,4'b0000,0,0,2'b00), "rst_miss");
    step(MISS_RD, mkexp(4'b1111,4'b0000,0,0,2'b01), "rst_memwait_redirect");
    do_reset();
    step(MISS,    mkexp(4'b1111,4'b0000,0,0,2'b00), "rst2_miss");
    step(HIT,     mkexp(4'b1110,4'b0000,0,0,2'b01), "rst2_dhit");
    step(IDLE1,   mkexp(4'b0001,4'b0000,1,0,2'b10), "rst2_exit_noflush");

    // Halt with a concurrent miss, then arbitrary stimulus cannot leave HALT.
    do_reset();
    step(mkin(0,0,1,0,0,0,0,0,0,0,1), mkexp(4'b0000,4'b0000,0,0,2'b00), "halt_miss");
    for (int k = 0; k < 10; k++) begin
      in_t r;
      r = in_t'($urandom_range(0, 32'h7FFFFFFF));
      step(r, mkexp(4'b1111,4'b0000,0,1,2'b11), $sformatf("halt_hold_%0d", k));
    end
    do_reset();
    step(IDLE1, mkexp(4'b0000,4'b0000,1,0,2'b00), "halt_reset_run");

`ifdef HAZARD_STATS_EN
    // One load-use stall plus three miss cycles.
    do_reset();
    step(LU,   mkexp(4'b1000,4'b0100,0,0,2'b00), "st_lu");
    step(MISS, mkexp(4'b1111,4'b0000,0,0,2'b00), "st_m1");
    step(MISS, mkexp(4'b1111,4'b0000,0,0,2'b01), "st_m2");
    step(MISS, mkexp(4'b1111,4'b0000,0,0,2'b01), "st_m3");
    check32("stall_cycles_4", stall_cycles, 32'd4);
    check32("flush_events_0", flush_events, 32'd0);
    do_reset();
    step(RD, mkexp(4'b0000,4'b1110,1,0,2'b00), "st_rd1");
    step(RD, mkexp(4'b0000,4'b1110,1,0,2'b00), "st_rd2");
    check32("flush_events_2", flush_events, 32'd2);
    check32("stall_cycles_0", stall_cycles, 32'd0);
    // Preset near the top and confirm saturation.
    dut.stall_cycles_q = 32'hFFFF_FFFE;
    dut.flush_events_q = 32'hFFFF_FFFE;
    step(RD, mkexp(4'b0000,4'b1110,1,0,2'b00), "sat_rd1");
    step(LU, mkexp(4'b1000,4'b0100,0,0,2'b00), "sat_lu1");
    step(RD, mkexp(4'b0000,4'b1110,1,0,2'b00), "sat_rd2");
    step(LU, mkexp(4'b1000,4'b0100,0,0,2'b00), "sat_lu2");
    check32("stall_cycles_sat", stall_cycles, 32'hFFFF_FFFF);
    check32("flush_events_sat", flush_events, 32'hFFFF_FFFF);
`else
    // Counters absent: ports stay zero across stalls and flushes.
    do_reset();
    step(LU,   mkexp(4'b1000,4'b0100,0,0,2'b00), "ns_lu");
    step(RD,   mkexp(4'b0000,4'b1110,1,0,2'b00), "ns_rd");
    step(MISS, mkexp(4'b1111,4'b0000,0,0,2'b00), "ns_miss");
    check32("stall_cycles_tied", stall_cycles, 32'd0);
    check32("flush_events_tied", flush_events, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
